// File: rtl/zeta_addr_gen.sv
// zeta_addr_gen: per-stage twiddle address sequencer for the NTT/INTT zeta ROM bank.
// Each stage counts butterfly pairs independently and emits both lane addresses plus ROM-aligned valid/done.
module zeta_addr_gen #(
  parameter int NTT_STAGE_CNT = 8,
  parameter int ROM_LATENCY   = 1
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              i_clear,
  input  logic                                              i_inverse,
  input  logic [NTT_STAGE_CNT-1:0]                          i_bf_valid,
  output logic [1:0][NTT_STAGE_CNT-1:0][NTT_STAGE_CNT-2:0]  o_rom_addr,
  output logic [NTT_STAGE_CNT-1:0]                          o_zeta_valid,
  output logic [NTT_STAGE_CNT-1:0]                          o_poly_done
);
  localparam int KW = NTT_STAGE_CNT - 2;
  localparam int AW = NTT_STAGE_CNT - 1;

  for (genvar s = 0; s < NTT_STAGE_CNT; s++) begin : g_stage
    localparam logic [AW-1:0] MASK = AW'((1 << s) - 1);
    logic [KW-1:0]        r_k;
    logic                 r_inv;
    logic [AW-1:0]        r_a0, r_a1;
    logic [ROM_LATENCY:0] r_vld, r_last;
    logic                 w_inv;
    logic [AW-1:0]        w_g0, w_g1;
    // the first pair of a polynomial uses the live mode, later pairs the latched one
    assign w_inv = (r_k == '0) ? i_inverse : r_inv;
    assign w_g0  = {r_k, 1'b0} >> (AW - s);
    assign w_g1  = {r_k, 1'b1} >> (AW - s);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_k    <= '0;
        r_inv  <= 1'b0;
        r_a0   <= '0;
        r_a1   <= '0;
        r_vld  <= '0;
        r_last <= '0;
      end else if (i_clear) begin
        r_k    <= '0;
        r_vld  <= '0;
        r_last <= '0;
      end else begin
        r_vld  <= {r_vld[ROM_LATENCY-1:0], i_bf_valid[s]};
        r_last <= {r_last[ROM_LATENCY-1:0], i_bf_valid[s] & (&r_k)};
        if (i_bf_valid[s]) begin
          r_k   <= r_k + KW'(1);
          r_inv <= w_inv;
          // group index never exceeds MASK, so the reversed address is a plain XOR
          r_a0  <= w_inv ? (MASK ^ w_g0) : w_g0;
          r_a1  <= w_inv ? (MASK ^ w_g1) : w_g1;
        end
      end
    assign o_rom_addr[0][s] = r_a0;
    assign o_rom_addr[1][s] = r_a1;
    assign o_zeta_valid[s]  = r_vld[ROM_LATENCY];
    assign o_poly_done[s]   = r_last[ROM_LATENCY];
  end
endmodule

// File: tb/tb_zeta_addr_gen.sv
// tb_zeta_addr_gen: randomized and directed stimulus for zeta_addr_gen against a pair-count reference model.
module tb_zeta_addr_gen;
  localparam int NS   = 8;
  localparam int NCYC = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic inverse = 1'b0;
  logic [NS-1:0] bf_valid = '0;
  logic [1:0][NS-1:0][NS-2:0] rom_addr;
  logic [NS-1:0] zeta_valid, poly_done;

  int tests = 0;
  int fails = 0;
  int n = 0;
  bit chk_en = 1'b0;

  int mk[NS];
  bit minv[NS];
  int ma[2][NS];
  bit ev[NS][NCYC];
  bit ed[NS][NCYC];

  zeta_addr_gen #(.NTT_STAGE_CNT(NS), .ROM_LATENCY(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_clear(clear),
    .i_inverse(inverse),
    .i_bf_valid(bf_valid),
    .o_rom_addr(rom_addr),
    .o_zeta_valid(zeta_valid),
    .o_poly_done(poly_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  function automatic int zaddr(int s, int k, int i, bit inv);
    int g;
    g = (2 * k + i) / (1 << (NS - 1 - s));
    return inv ? ((1 << s) - 1 - g) : g;
  endfunction

  // reference model: pair index per stage, scheduled valid/done by edge number
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) begin
        mk[s] = 0;
        minv[s] = 1'b0;
        ma[0][s] = 0;
        ma[1][s] = 0;
        for (int c = 0; c < NCYC; c++) begin
          ev[s][c] = 1'b0;
          ed[s][c] = 1'b0;
        end
      end
    end else begin
      n++;
      if (clear) begin
        for (int s = 0; s < NS; s++) begin
          mk[s] = 0;
          for (int c = n; c < NCYC; c++) begin
            ev[s][c] = 1'b0;
            ed[s][c] = 1'b0;
          end
        end
      end else begin
        for (int s = 0; s < NS; s++) begin
          if (bf_valid[s]) begin
            if (mk[s] == 0) minv[s] = inverse;
            ma[0][s] = zaddr(s, mk[s], 0, minv[s]);
            ma[1][s] = zaddr(s, mk[s], 1, minv[s]);
            if (n + 1 < NCYC) begin
              ev[s][n+1] = 1'b1;
              ed[s][n+1] = (mk[s] == 63);
            end
            mk[s] = (mk[s] + 1) % 64;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0][NS-1:0][NS-2:0] ea;
    logic [NS-1:0] evv, edv;
    if (chk_en) begin
      for (int s = 0; s < NS; s++) begin
        ea[0][s] = 7'(ma[0][s]);
        ea[1][s] = 7'(ma[1][s]);
        evv[s] = ev[s][n];
        edv[s] = ed[s][n];
      end
      chk("model_rom_addr", rom_addr, ea);
      chk("model_zeta_valid", zeta_valid, evv);
      chk("model_poly_done", poly_done, edv);
    end
  end

  task automatic drive(input logic [NS-1:0] b, input logic inv, input logic clr);
    @(negedge clk);
    bf_valid = b;
    inverse = inv;
    clear = clr;
  endtask

  initial begin
    logic [NS-1:0] b;
    repeat (3) @(negedge clk);
    chk("reset_addr", rom_addr, '0);
    chk("reset_zv", zeta_valid, '0);
    chk("reset_pd", poly_done, '0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // forward stream on stages 7, 1 and 0
    for (int j = 0; j <= 66; j++) begin
      drive(j < 64 ? 8'h83 : 8'h00, 1'b0, 1'b0);
      if (j >= 1 && j <= 64) begin
        chk("fwd7_lane0", rom_addr[0][7], 2 * (j - 1));
        chk("fwd7_lane1", rom_addr[1][7], 2 * (j - 1) + 1);
      end
      if (j == 32) chk("fwd1_k31", {rom_addr[1][1], rom_addr[0][1]}, {7'd0, 7'd0});
      if (j == 33) chk("fwd1_k32", {rom_addr[1][1], rom_addr[0][1]}, {7'd1, 7'd1});
      if (j == 64) chk("fwd0_k63", {rom_addr[1][0], rom_addr[0][0]}, {7'd0, 7'd0});
      if (j == 65) chk("done7_pulse", {zeta_valid[7], poly_done[7]}, 2'b11);
      if (j == 66) chk("done7_after", {zeta_valid[7], poly_done[7]}, 2'b00);
    end

    // stage 3: inverse polynomial with a mid-poly toggle, then a forward one
    for (int p = 0; p < 2; p++)
      for (int j = 0; j < 64; j++) begin
        drive(8'h08, p == 0 ? (j < 20) : 1'b0, 1'b0);
        if (p == 0 && j == 1) chk("inv3_k0", {rom_addr[1][3], rom_addr[0][3]}, {7'd7, 7'd7});
        if (p == 0 && j == 17) chk("inv3_k16", {rom_addr[1][3], rom_addr[0][3]}, {7'd5, 7'd5});
        if (p == 1 && j == 0) chk("inv3_k63", {rom_addr[1][3], rom_addr[0][3]}, {7'd0, 7'd0});
        if (p == 1 && j == 1) chk("fwd3_k0", {rom_addr[1][3], rom_addr[0][3]}, {7'd0, 7'd0});
        if (p == 1 && j == 17) chk("fwd3_k16", {rom_addr[1][3], rom_addr[0][3]}, {7'd2, 7'd2});
      end
    drive(8'h00, 1'b0, 1'b0);
    chk("fwd3_k63", {rom_addr[1][3], rom_addr[0][3]}, {7'd7, 7'd7});

    // random gaps on stages 2 and 6
    for (int j = 0; j < 300; j++) begin
      b = '0;
      b[2] = 1'($urandom);
      b[6] = 1'($urandom);
      drive(b, 1'b0, 1'b0);
    end

    // fully random traffic with mode changes and sporadic clears
    for (int j = 0; j < 1500; j++)
      drive(NS'($urandom), 1'($urandom), ($urandom % 64) == 0);

    // clear at k = 10 on stage 5 with a colliding bf_valid
    drive(8'h00, 1'b0, 1'b1);
    for (int j = 0; j < 10; j++) drive(8'h20, 1'b0, 1'b0);
    drive(8'h20, 1'b0, 1'b1);
    chk("pre_clr_addr5", {rom_addr[1][5], rom_addr[0][5]}, {7'd4, 7'd4});
    for (int j = 0; j < 3; j++) begin
      drive(8'h00, 1'b0, 1'b0);
      chk("clr_zv5", zeta_valid[5], 1'b0);
    end
    drive(8'h20, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    chk("post_clr_addr5", {rom_addr[1][5], rom_addr[0][5]}, {7'd0, 7'd0});
    drive(8'h00, 1'b0, 1'b0);
    chk("post_clr_zv5", zeta_valid[5], 1'b1);

    // asynchronous reset in the middle of a stream
    for (int j = 0; j < 10; j++) drive(8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_addr7", {rom_addr[1][7], rom_addr[0][7]}, {7'd19, 7'd18});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_addr", rom_addr, '0);
    chk("async_rst_zv", zeta_valid, '0);
    chk("async_rst_pd", poly_done, '0);
    drive(8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(8'h80, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    chk("restart_addr7", {rom_addr[1][7], rom_addr[0][7]}, {7'd1, 7'd0});
    repeat (4) drive(8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
    $finish;
  end
endmodule
